// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, framebuffer geometry and pipeline types.
package vga_pkg;
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_TOT  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_TOT  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int FB_W = 160;
    localparam int FB_H = 120;

    typedef logic [9:0] cnt_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic fs;
    } vid_t;

    localparam vid_t VID_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, fs: 1'b0};

    function automatic logic [3:0] chan(input logic bit_on, input logic blank);
        return (bit_on && !blank) ? 4'hF : 4'h0;
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v counters with raw (undelayed) sync, blank and frame-start flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic clk,
    input  logic resetn,
    output cnt_t h,
    output cnt_t v,
    output vid_t raw
);
    localparam cnt_t H_LAST = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t HS_LO  = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_HI  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam cnt_t VS_LO  = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_HI  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);
    localparam cnt_t HV     = cnt_t'(H_VIS);
    localparam cnt_t VV     = cnt_t'(V_VIS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= (h == H_LAST) ? '0 : h + 1'b1;
            if (h == H_LAST)
                v <= (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    assign raw = '{
        hs:    !(h >= HS_LO && h <= HS_HI),
        vs:    !(v >= VS_LO && v <= VS_HI),
        blank: (h >= HV) || (v >= VV),
        fs:    (h == '0) && (v == '0)
    };
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: scans a 160x120 RGB111 framebuffer out as 640x480 VGA with 4x pixel replication.
// Sync/blank travel two stages so they line up with read data from the 1-cycle framebuffer.
module fb_scanout
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] fb_x,
    output logic [7:0] fb_y,
    input  logic [2:0] fb_dout,
    output logic       draw_ok,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_start
);
    cnt_t h, v;
    vid_t raw, s1;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk),
        .resetn(resetn),
        .h(h),
        .v(v),
        .raw(raw)
    );

    // Clamp addresses in the porches so the read never leaves the framebuffer.
    assign fb_x    = (h >= cnt_t'(H_VIS)) ? 8'(FB_W - 1) : h[9:2];
    assign fb_y    = (v >= cnt_t'(V_VIS)) ? 8'(FB_H - 1) : v[9:2];
    assign draw_ok = v >= cnt_t'(V_VIS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1          <= VID_IDLE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
        end else begin
            s1          <= raw;
            hsync       <= s1.hs;
            vsync       <= s1.vs;
            blank       <= s1.blank;
            frame_start <= s1.fs;
            vga_r       <= chan(fb_dout[2], s1.blank);
            vga_g       <= chan(fb_dout[1], s1.blank);
            vga_b       <= chan(fb_dout[0], s1.blank);
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: full-frame scan of fb_scanout (shortened vertical timing) against an arithmetic model.
module tb_fb_scanout;
    localparam int LINE   = 800;
    localparam int V_VIS  = 20;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = LINE * V_TOT;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] fb_x, fb_y;
    logic [2:0] fb_dout = 3'd0;
    logic       draw_ok, hsync, vsync, blank, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [2:0] mem [0:19199];
    int         n_chk = 0;
    int         n_err = 0;
    int         cur_k = 0;

    fb_scanout #(
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .fb_x(fb_x),
        .fb_y(fb_y),
        .fb_dout(fb_dout),
        .draw_ok(draw_ok),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    // Framebuffer with one-cycle synchronous read latency
    always @(posedge clk) fb_dout <= mem[int'(fb_y) * 160 + int'(fb_x)];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @k=%0d: got %0h expected %0h", tag, cur_k, got, exp);
        end
    endtask

    function automatic logic [15:0] vid_now();
        return {hsync, vsync, blank, frame_start, vga_r, vga_g, vga_b};
    endfunction

    // Output at cycle k describes counter position k-2; counter position c is (c%800, c/800).
    function automatic logic [15:0] exp_vid(input int k);
        int c, h, v;
        logic bl;
        logic [2:0] d;
        if (k < 2) return 16'hE000;
        c  = k - 2;
        h  = c % LINE;
        v  = (c / LINE) % V_TOT;
        bl = (h >= 640) || (v >= V_VIS);
        d  = bl ? 3'd0 : mem[(v / 4) * 160 + h / 4];
        return {!(h >= 656 && h <= 751), !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC),
                bl, (c % FRAME) == 0, {4{d[2]}}, {4{d[1]}}, {4{d[0]}}};
    endfunction

    task automatic run(input int n, input bit fills);
        int h, v, hs_len, vs_len, dok_len, last_fs;
        hs_len = 0; vs_len = 0; dok_len = 0; last_fs = -1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            cur_k = k;
            h = k % LINE;
            v = (k / LINE) % V_TOT;
            chk("video", vid_now(), exp_vid(k));
            chk("fb_x", fb_x, (h >= 640) ? 159 : h / 4);
            chk("fb_y", fb_y, (v >= V_VIS) ? 119 : v / 4);
            chk("draw_ok", draw_ok, v >= V_VIS);
            if (frame_start) begin
                chk("fs_gap", (last_fs < 0) ? k : k - last_fs, (last_fs < 0) ? 2 : FRAME);
                last_fs = k;
            end
            if (!hsync) hs_len++;
            else if (hs_len > 0) begin chk("hs_width", hs_len, 96); hs_len = 0; end
            if (!vsync) vs_len++;
            else if (vs_len > 0) begin chk("vs_width", vs_len, V_SYNC * LINE); vs_len = 0; end
            if (draw_ok) begin
                if (dok_len == 0) chk("dok_rise", k % FRAME, V_VIS * LINE);
                dok_len++;
            end else if (dok_len > 0) begin
                chk("dok_width", dok_len, (V_TOT - V_VIS) * LINE);
                chk("dok_fall", k % FRAME, 0);
                dok_len = 0;
            end
            if (fills && k == 2 + 4 * LINE + 8) chk("pix_8_4", {vga_r, vga_g, vga_b}, 12'h0FF);
            if (fills && k == 2 * FRAME + 2 + 639) chk("h639_vis", {blank, vga_r, vga_g, vga_b}, 13'h0FFF);
            if (fills && k == 2 * FRAME + 2 + 640) chk("h640_blank", {blank, vga_r, vga_g, vga_b}, 13'h1000);
            // Swap framebuffer contents deep in vertical blank: frame 1 random, frame 2 all white
            if (fills && h == 0 && v == V_VIS + 1) begin
                for (int i = 0; i < 19200; i++)
                    mem[i] = (k / FRAME == 0) ? 3'($urandom) : 3'd7;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) mem[i] = 3'(((i % 160) + (i / 160)) % 8);
        repeat (3) @(negedge clk);
        chk("rst_video", vid_now(), 16'hE000);
        chk("rst_draw_ok", draw_ok, 0);
        chk("rst_addr", {fb_x, fb_y}, 0);
        resetn = 1'b1;
        run(2 * FRAME + 10 * LINE + 300 + 1, 1'b1);
        chk("pre_rst_active", vid_now(), exp_vid(cur_k));
        #5 resetn = 1'b0;
        #1;
        chk("async_video", vid_now(), 16'hE000);
        chk("async_draw_ok", draw_ok, 0);
        chk("async_addr", {fb_x, fb_y}, 0);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        @(negedge clk);
        chk("held_video", vid_now(), 16'hE000);
        resetn = 1'b1;
        run(FRAME + 100, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
